// File: rtl/sseg_scan_mux_if.sv
// Host-side bundle for sseg_scan_mux: frame data and load strobe in, segment/digit pins out.
interface sseg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic                      blank_lz;
    logic [6:0]                sseg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     dgt_n;
    logic                      frame_start;

    modport master (
        output load, digits_in, dp_in, blink_mask, blank_lz,
        input  sseg, dp, dgt_n, frame_start
    );

    modport slave (
        input  load, digits_in, dp_in, blink_mask, blank_lz,
        output sseg, dp, dgt_n, frame_start
    );
endinterface

// File: rtl/sseg_scan_mux.sv
// Scanned N-digit seven-segment driver: hex decode, frame double-buffering, leading-zero
// blanking. Per-digit blinking is built only when SSEG_BLINK_EN is defined.
module sseg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    sseg_scan_mux_if.slave bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_err
            $error("sseg_scan_mux: parameter out of range");
        end
    endgenerate

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h7E;
            4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;
            4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;
            4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;
            4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h0D;
            4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;
            4'hF: hex7 = 7'h47;
            default: hex7 = 7'h00;
        endcase
    endfunction

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         stg_dig_q, stg_dig_d, shd_dig_q, shd_dig_d;
    logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
    logic                  pending_q, pending_d;
    logic [6:0]            sseg_q, sseg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dgt_n_q, dgt_n_d;
    logic                  fs_q, fs_d;

    logic                  tc_s, wrap_s;
    logic [3:0]            nib_s;
    logic                  dp_bit_s, lz_bit_s, tail_zero_s, dark_s;

`ifdef SSEG_BLINK_EN
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] stg_blk_q, stg_blk_d, shd_blk_q, shd_blk_d;
    logic [FRM_W-1:0]      frm_q, frm_d;
    logic                  bph_q, bph_d;
    logic                  run_q, run_d;
    logic                  blk_bit_s;
`else
    logic                  unused_blink_s;
    assign unused_blink_s = ^bus.blink_mask;
`endif

    // Scan timing, double-buffer transfer and blink phase bookkeeping.
    always_comb begin
        tc_s      = (cnt_q == CNT_TC);
        wrap_s    = tc_s && (idx_q == IDX_LAST);
        cnt_d     = tc_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
        if (wrap_s) begin
            idx_d = {IDX_W{1'b0}};
        end else if (tc_s) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end

        stg_dig_d = stg_dig_q;
        stg_dp_d  = stg_dp_q;
        shd_dig_d = shd_dig_q;
        shd_dp_d  = shd_dp_q;
        pending_d = pending_q;
`ifdef SSEG_BLINK_EN
        stg_blk_d = stg_blk_q;
        shd_blk_d = shd_blk_q;
`endif
        // A load coinciding with the frame-start TC goes straight to shadow.
        if (wrap_s && bus.load) begin
            stg_dig_d = bus.digits_in;
            stg_dp_d  = bus.dp_in;
            shd_dig_d = bus.digits_in;
            shd_dp_d  = bus.dp_in;
            pending_d = 1'b0;
`ifdef SSEG_BLINK_EN
            stg_blk_d = bus.blink_mask;
            shd_blk_d = bus.blink_mask;
`endif
        end else if (wrap_s && pending_q) begin
            shd_dig_d = stg_dig_q;
            shd_dp_d  = stg_dp_q;
            pending_d = 1'b0;
`ifdef SSEG_BLINK_EN
            shd_blk_d = stg_blk_q;
`endif
        end else if (bus.load) begin
            stg_dig_d = bus.digits_in;
            stg_dp_d  = bus.dp_in;
            pending_d = 1'b1;
`ifdef SSEG_BLINK_EN
            stg_blk_d = bus.blink_mask;
`endif
        end else begin
            pending_d = pending_q;
        end

`ifdef SSEG_BLINK_EN
        // run_q skips the very first frame start, which closes no frame.
        run_d = run_q;
        frm_d = frm_q;
        bph_d = bph_q;
        if (wrap_s && run_q) begin
            if (frm_q == FRM_LAST) begin
                frm_d = {FRM_W{1'b0}};
                bph_d = ~bph_q;
            end else begin
                frm_d = frm_q + FRM_W'(1);
            end
        end else if (wrap_s) begin
            run_d = 1'b1;
        end else begin
            run_d = run_q;
        end
`endif
    end

    // Select the next digit from the post-update shadow and build the registered pin values.
    always_comb begin
        nib_s       = 4'h0;
        dp_bit_s    = 1'b0;
        lz_bit_s    = 1'b0;
        tail_zero_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            tail_zero_s = tail_zero_s && (shd_dig_d[4*i +: 4] == 4'h0);
            nib_s       = nib_s | ({4{idx_d == IDX_W'(i)}} & shd_dig_d[4*i +: 4]);
            dp_bit_s    = dp_bit_s | ((idx_d == IDX_W'(i)) & shd_dp_d[i]);
            lz_bit_s    = lz_bit_s | ((idx_d == IDX_W'(i)) & tail_zero_s & (i != 0));
        end
`ifdef SSEG_BLINK_EN
        blk_bit_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            blk_bit_s = blk_bit_s | ((idx_d == IDX_W'(i)) & shd_blk_d[i]);
        end
        dark_s = bph_d && blk_bit_s;
`else
        dark_s = 1'b0;
`endif
        fs_d = wrap_s;
        if (tc_s) begin
            sseg_d = (dark_s || (bus.blank_lz && lz_bit_s)) ? 7'h00 : hex7(nib_s);
            dp_d   = dark_s ? 1'b0 : dp_bit_s;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dgt_n_d[i] = (idx_d != IDX_W'(i));
            end
        end else begin
            sseg_d  = sseg_q;
            dp_d    = dp_q;
            dgt_n_d = dgt_n_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            idx_q     <= IDX_LAST;
            stg_dig_q <= {DW{1'b0}};
            stg_dp_q  <= {NUM_DIGITS{1'b0}};
            shd_dig_q <= {DW{1'b0}};
            shd_dp_q  <= {NUM_DIGITS{1'b0}};
            pending_q <= 1'b0;
            sseg_q    <= 7'h00;
            dp_q      <= 1'b0;
            dgt_n_q   <= {NUM_DIGITS{1'b1}};
            fs_q      <= 1'b0;
`ifdef SSEG_BLINK_EN
            stg_blk_q <= {NUM_DIGITS{1'b0}};
            shd_blk_q <= {NUM_DIGITS{1'b0}};
            frm_q     <= {FRM_W{1'b0}};
            bph_q     <= 1'b0;
            run_q     <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stg_dig_q <= stg_dig_d;
            stg_dp_q  <= stg_dp_d;
            shd_dig_q <= shd_dig_d;
            shd_dp_q  <= shd_dp_d;
            pending_q <= pending_d;
            sseg_q    <= sseg_d;
            dp_q      <= dp_d;
            dgt_n_q   <= dgt_n_d;
            fs_q      <= fs_d;
`ifdef SSEG_BLINK_EN
            stg_blk_q <= stg_blk_d;
            shd_blk_q <= shd_blk_d;
            frm_q     <= frm_d;
            bph_q     <= bph_d;
            run_q     <= run_d;
`endif
        end
    end

    assign bus.sseg        = sseg_q;
    assign bus.dp          = dp_q;
    assign bus.dgt_n       = dgt_n_q;
    assign bus.frame_start = fs_q;
endmodule
